// File: rtl/cmd_sink_fifo.sv
// Command sink: tag-checking first-word-fall-through FIFO with drop accounting.
// Optional push/pop statistics counters are enabled by defining CMD_SINK_FIFO_STATS_EN.
module cmd_sink_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [1:0]  ADDR_TAG = 2'b10,
    parameter logic [1:0]  DATA_TAG = 2'b01
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_cmd_valid,
    input  logic                       in_cmd,
    input  logic [9:0]                 in_addr,
    input  logic [9:0]                 in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_cmd,
    output logic [7:0]                 out_addr,
    output logic [7:0]                 out_data,
    output logic                       out_tag_err,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    input  logic                       ovf_clr,
    output logic [15:0]                pushed_cnt,
    output logic [15:0]                popped_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic       cmd;
        logic [7:0] addr;
        logic [7:0] data;
        logic       tag_err;
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      wr_entry;
    entry_t      head;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        push, pop, drop;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level     = wr_ptr_q - rd_ptr_q;
        out_valid = !empty;
        pop       = out_valid && out_ready;
        // A pop frees a slot this cycle, so a full FIFO can still accept.
        push      = in_cmd_valid && (!full || pop);
        drop      = in_cmd_valid && full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        wr_entry.cmd     = in_cmd;
        wr_entry.addr    = in_addr[7:0];
        wr_entry.data    = in_data[7:0];
        wr_entry.tag_err = (in_addr[9:8] != ADDR_TAG) || (in_data[9:8] != DATA_TAG);

        head        = mem_q[rd_ptr_q[AW-1:0]];
        out_cmd     = head.cmd;
        out_addr    = head.addr;
        out_data    = head.data;
        out_tag_err = head.tag_err;
    end

    // Clear first, then a same-cycle drop overrides it.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

`ifdef CMD_SINK_FIFO_STATS_EN
    logic [15:0] pushed_cnt_q, popped_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pushed_cnt_q <= 16'd0;
            popped_cnt_q <= 16'd0;
        end else begin
            if (push) pushed_cnt_q <= pushed_cnt_q + 16'd1;
            if (pop)  popped_cnt_q <= popped_cnt_q + 16'd1;
        end
    end

    assign pushed_cnt = pushed_cnt_q;
    assign popped_cnt = popped_cnt_q;
`else
    assign pushed_cnt = 16'd0;
    assign popped_cnt = 16'd0;
`endif

endmodule

// File: doc/cmd_sink_fifo.md
Name: cmd_sink_fifo

Overview:
- Downstream consumer of the command-forwarding stage's output bus (cmd_valid/cmd/addr/data, no backpressure).
- Buffers each forwarded command in a first-word-fall-through FIFO and presents it to a consumer over a valid/ready handshake.
- Checks the 2-bit tag prefixes the forwarding stage inserts (addr[9:8]=2'b10, data[9:8]=2'b01), strips them, and flags mismatches.
- Counts commands dropped because the upstream stage cannot be stalled.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_TAG, 2'b10, expected in_addr[9:8].
- DATA_TAG, 2'b01, expected in_data[9:8].

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_cmd_valid  in  1  command present this cycle.
- in_cmd  in  1  command bit.
- in_addr  in  10  tagged address.
- in_data  in  10  tagged data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_cmd  out  1  head command.
- out_addr  out  8  head address, tag stripped.
- out_data  out  8  head data, tag stripped.
- out_tag_err  out  1  head entry had an address or data tag mismatch.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- overflow  out  1  sticky: at least one command dropped.
- drop_cnt  out  8  dropped-command count, saturates at 255.
- ovf_clr  in  1  clears overflow and drop_cnt.
- pushed_cnt  out  16  see Optional Feature.
- popped_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert usage):
  - Pointers, level, overflow, drop_cnt, pushed_cnt and popped_cnt go to 0; empty=1, full=0, out_valid=0.
  - Storage contents are don't-care; out_cmd/addr/data/tag_err are undefined while empty.
  - Reset mid-operation discards all entries immediately.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits with a wrap bit. empty when the pointers are equal; full when the MSBs differ and the rest are equal. level = wr_ptr - rd_ptr (modular).
- push = in_cmd_valid && (!full || pop).
- pop = out_valid && out_ready.
- Write: on push, store {in_cmd, in_addr[7:0], in_data[7:0], tag_err}, where tag_err = (in_addr[9:8]!=ADDR_TAG) || (in_data[9:8]!=DATA_TAG). wr_ptr increments and wraps naturally.
- Read (FWFT): out_valid = !empty. Head fields are driven from storage[rd_ptr]. On pop, rd_ptr increments.
- Latency: a command pushed into an empty FIFO at edge N gives out_valid=1 after edge N. There is no same-cycle bypass; out_valid depends only on registered state.
- Push and pop in the same cycle:
  - Both are performed and level is unchanged.
  - Also holds when full: the slot freed by the pop is written.
  - When empty, only the push occurs, since pop requires out_valid.
- Drop: in_cmd_valid && full && !pop drops the command, sets overflow=1 and increments drop_cnt, saturating at 255.
- ovf_clr: clears overflow and drop_cnt at the next edge. If a drop occurs in the same cycle, set wins: overflow=1 and drop_cnt=1.
- Handshake: out_valid never deasserts without a pop or reset. Head fields are stable while out_valid && !out_ready.

Optional Feature:
- Macro: CMD_SINK_FIFO_STATS_EN.
- Defined: pushed_cnt increments on every push and popped_cnt on every pop. Both are 16-bit, wrap modulo 2^16, are unaffected by ovf_clr, and clear on reset.
- Undefined: no counter logic; pushed_cnt and popped_cnt are tied to 0.

Test Plan:
- After reset, single command in_cmd=1, in_addr=10'h2A5, in_data=10'h13C -> next cycle out_valid=1, out_cmd=1, out_addr=8'hA5, out_data=8'h3C, out_tag_err=0, level=1; pop with out_ready=1 -> empty=1.
- Bad tags: in_addr=10'h0A5 -> out_tag_err=1. Separately, in_data=10'h23C -> out_tag_err=1.
- Fill with out_ready=0: 8 pushes addr 0x200..0x207 -> full=1, level=8. Two more pushes -> overflow=1, drop_cnt=2. Drain -> addrs 00..07 in order.
- Full plus same-cycle push and pop: push addr 0x2FF -> level stays 8, drop_cnt unchanged, 0x2FF emerges 8th after the pop.
- 300 drops -> drop_cnt=255. ovf_clr alone -> overflow=0, drop_cnt=0. ovf_clr with a simultaneous drop -> overflow=1, drop_cnt=1.
- Assert reset with level=5 -> out_valid=0, level=0 immediately (async). With CMD_SINK_FIFO_STATS_EN, 70000 push/pop pairs -> pushed_cnt=popped_cnt=4464.
